// File: rtl/rv_div_pkg.sv
// Shared types and helpers for the iterative RISC-V divider.
package rv_div_pkg;

    // Operation encoding taken directly from funct3[1:0]
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    // DIV and REM treat their operands as two's-complement values
    function automatic logic is_signed_op(div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder instead of the quotient
    function automatic logic is_rem_op(div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rv_iter_divider_if.sv
// Request/response bundle between the EX stage and the divider.
interface rv_iter_divider_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            div_by_zero;
    logic            overflow;

    // Pipeline side: issues requests and consumes results
    modport master (
        output in_valid, funct3, a, b, out_ready,
        input  in_ready, out_valid, result, div_by_zero, overflow
    );

    // Divider side
    modport slave (
        input  in_valid, funct3, a, b, out_ready,
        output in_ready, out_valid, result, div_by_zero, overflow
    );
endinterface

// File: rtl/rv_div_step.sv
// Combinational block of UNROLL chained radix-2 restoring division steps.
// Operates on magnitudes only; sign handling lives in the top level.
module rv_div_step #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quot_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quot_out
);

    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q;
    logic [XLEN:0]   trial;

    // Shift {rem,quot} left, trial-subtract the divisor and keep the
    // difference whenever it does not borrow. The partial remainder is
    // always below the divisor, so the shifted value fits in XLEN+1 bits and
    // the accepted difference fits back into XLEN bits.
    always_comb begin
        r     = rem_in;
        q     = quot_in;
        trial = '0;
        for (int i = 0; i < UNROLL; i++) begin
            trial = {r, q[XLEN-1]};
            q     = {q[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, divisor}) begin
                r    = trial[XLEN-1:0] - divisor;
                q[0] = 1'b1;
            end else begin
                r = trial[XLEN-1:0];
            end
        end
        rem_out  = r;
        quot_out = q;
    end

endmodule

// File: rtl/rv_iter_divider.sv
// Multi-cycle RV32M/RV64M DIV/DIVU/REM/REMU unit with valid/ready handshake.
// Special cases (divide by zero, signed MIN/-1) bypass the datapath.
module rv_iter_divider
    import rv_div_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    output logic               busy,
    rv_iter_divider_if.slave   bus
);

    localparam int              STEPS = XLEN / UNROLL;
    localparam int              CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]  SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    div_state_e      state_next;
    logic [CNT_W-1:0] count;

    div_op_e         op_q;
    logic            neg_quot_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quot_step;

    logic [XLEN-1:0] result_q;
    logic            dbz_q;
    logic            ovf_q;
    logic            out_valid_q;

    div_op_e         op_in;
    logic            signed_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic            b_zero_in;
    logic            ovf_in;
    logic            special_in;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] final_res;
    logic            accept;
    logic            release_result;

    // A flush in the same cycle as a request blocks the accept
    assign accept         = bus.in_valid && (state == IDLE) && !flush;
    assign release_result = out_valid_q && bus.out_ready;

    // Decode the incoming request: op, operand signs, magnitudes, special cases
    always_comb begin
        op_in      = div_op_e'(bus.funct3[1:0]);
        signed_in  = is_signed_op(op_in);
        a_neg_in   = signed_in && bus.a[XLEN-1];
        b_neg_in   = signed_in && bus.b[XLEN-1];
        a_mag_in   = a_neg_in ? -bus.a : bus.a;
        b_mag_in   = b_neg_in ? -bus.b : bus.b;
        b_zero_in  = (bus.b == '0);
        ovf_in     = signed_in && (bus.a == SIGNED_MIN) && (bus.b == '1);
        special_in = b_zero_in || ovf_in;
        if (b_zero_in) begin
            special_res = is_rem_op(op_in) ? bus.a : '1;
        end else begin
            special_res = is_rem_op(op_in) ? '0 : bus.a;
        end
    end

    // Sign correction applied once the magnitudes have been divided
    always_comb begin
        quot_fix  = neg_quot_q ? -quot_q : quot_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
        final_res = is_rem_op(op_q) ? rem_fix : quot_fix;
    end

    rv_div_step #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_step (
        .rem_in   (rem_q),
        .quot_in  (quot_q),
        .divisor  (divisor_q),
        .rem_out  (rem_step),
        .quot_out (quot_step)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (release_result) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Operand capture on accept, iteration in CALC, sign fix-up in FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_DIV;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            count      <= '0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op_in;
                        neg_quot_q <= a_neg_in ^ b_neg_in;
                        neg_rem_q  <= a_neg_in;
                        rem_q      <= '0;
                        quot_q     <= a_mag_in;
                        divisor_q  <= b_mag_in;
                        count      <= '0;
                        dbz_q      <= b_zero_in;
                        ovf_q      <= ovf_in && !b_zero_in;
                        if (special_in) begin
                            result_q <= special_res;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_step;
                    quot_q <= quot_step;
                    count  <= count + 1'b1;
                end
                FIX: begin
                    result_q <= final_res;
                end
                default: begin
                end
            endcase
        end
    end

    // Result becomes visible one edge after DONE is entered and stays until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state == DONE) && !release_result;
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign busy            = (state != IDLE);

endmodule
